// File: rtl/ulpi_reg_read.sv
// ULPI immediate register read engine: sends a register-read TX CMD, turns the
// bus around, captures the returned byte and reports DONE or ERROR.
module ulpi_reg_read #(
  parameter int MAX_RETRY    = 3,
  parameter int TURN_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       READ_DATA,
  input  logic [5:0] ADDR,
  output logic [7:0] DATA,
  output logic       DONE,
  output logic       ERROR,
  output logic       BUSY,
  input  logic       DIR,
  input  logic       NXT,
  output logic       STP,
  input  logic [7:0] ULPI_DATA_IN,
  output logic [7:0] ULPI_DATA_OUT,
  output logic       ULPI_DATA_OE,
  output logic [2:0] state_dbg
);

  // Handshake: READ_DATA is a request strobe accepted on any edge where BUSY=0;
  // exactly one of DONE/ERROR pulses for one cycle per accepted request.

  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int TW = $clog2(TURN_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BUS = 3'd1,
    TXCMD    = 3'd2,
    TURN_IN  = 3'd3,
    READ     = 3'd4,
    TURN_OUT = 3'd5
  } state_t;

  state_t        state, state_d;
  logic [5:0]    addr_q, addr_d;
  logic [RW-1:0] retry_q, retry_d, retry_inc;
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
  logic [7:0]    data_d, out_d;
  logic          done_d, error_d, busy_d, oe_d, abort;

  assign retry_inc = retry_q + 1'b1;
  assign tmo_inc   = tmo_q + 1'b1;
  assign state_dbg = state;

  always_comb begin
    state_d = state;
    addr_d  = addr_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    data_d  = DATA;
    done_d  = 1'b0;
    error_d = 1'b0;
    busy_d  = BUSY;
    out_d   = ULPI_DATA_OUT;
    oe_d    = ULPI_DATA_OE;
    abort   = 1'b0;
    case (state)
      IDLE: begin
        busy_d = 1'b0;
        oe_d   = 1'b0;
        out_d  = 8'h00;
        if (READ_DATA) begin
          addr_d  = ADDR;
          busy_d  = 1'b1;
          retry_d = '0;
          if (!DIR) begin
            state_d = TXCMD;
            out_d   = {2'b11, ADDR};
            oe_d    = 1'b1;
          end else begin
            state_d = WAIT_BUS;
          end
        end
      end
      WAIT_BUS: begin
        oe_d  = 1'b0;
        out_d = 8'h00;
        if (!DIR) begin
          state_d = TXCMD;
          out_d   = {2'b11, addr_q};
          oe_d    = 1'b1;
        end
      end
      TXCMD: begin
        if (DIR) begin
          abort = 1'b1;
        end else if (NXT) begin
          state_d = TURN_IN;
          oe_d    = 1'b0;
          out_d   = 8'h00;
          tmo_d   = '0;
        end
      end
      TURN_IN: begin
        if (DIR) begin
          if (NXT) abort = 1'b1;
          else     state_d = READ;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TW'(TURN_TIMEOUT)) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      READ: begin
        if (DIR) begin
          data_d  = ULPI_DATA_IN;
          done_d  = 1'b1;
          state_d = TURN_OUT;
        end else begin
          abort = 1'b1;
        end
      end
      TURN_OUT: begin
        if (!DIR) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        oe_d    = 1'b0;
        out_d   = 8'h00;
      end
    endcase

    // Any abort releases the bus at once; retries go back through WAIT_BUS.
    if (abort) begin
      oe_d    = 1'b0;
      out_d   = 8'h00;
      retry_d = retry_inc;
      if (retry_inc > RW'(MAX_RETRY)) begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end else begin
        state_d = WAIT_BUS;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      addr_q        <= 6'h00;
      retry_q       <= '0;
      tmo_q         <= '0;
      DATA          <= 8'h00;
      DONE          <= 1'b0;
      ERROR         <= 1'b0;
      BUSY          <= 1'b0;
      STP           <= 1'b0;
      ULPI_DATA_OUT <= 8'h00;
      ULPI_DATA_OE  <= 1'b0;
    end else begin
      state         <= state_d;
      addr_q        <= addr_d;
      retry_q       <= retry_d;
      tmo_q         <= tmo_d;
      DATA          <= data_d;
      DONE          <= done_d;
      ERROR         <= error_d;
      BUSY          <= busy_d;
      STP           <= 1'b0;
      ULPI_DATA_OUT <= out_d;
      ULPI_DATA_OE  <= oe_d;
    end
  end

endmodule

// File: tb/tb_ulpi_reg_read.sv
// Directed bench for ulpi_reg_read: the PHY side is driven cycle by cycle and
// outputs are checked 1 ns after each rising edge against hand-derived values.
module tb_ulpi_reg_read;

  logic       clk = 1'b0;
  logic       rst;
  logic       READ_DATA;
  logic [5:0] ADDR;
  logic [7:0] DATA;
  logic       DONE, ERROR, BUSY, DIR, NXT, STP;
  logic [7:0] ULPI_DATA_IN, ULPI_DATA_OUT;
  logic       ULPI_DATA_OE;
  logic [2:0] state_dbg;

  int tests = 0;
  int fails = 0;

  ulpi_reg_read #(.MAX_RETRY(3), .TURN_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .READ_DATA(READ_DATA), .ADDR(ADDR), .DATA(DATA),
    .DONE(DONE), .ERROR(ERROR), .BUSY(BUSY), .DIR(DIR), .NXT(NXT), .STP(STP),
    .ULPI_DATA_IN(ULPI_DATA_IN), .ULPI_DATA_OUT(ULPI_DATA_OUT),
    .ULPI_DATA_OE(ULPI_DATA_OE), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive PHY inputs for one cycle, then land 1 ns after the next rising edge.
  task automatic step(input logic d, input logic n, input logic [7:0] di);
    DIR = d;
    NXT = n;
    ULPI_DATA_IN = di;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; READ_DATA = 1'b0; ADDR = 6'h00;
    DIR = 1'b0; NXT = 1'b0; ULPI_DATA_IN = 8'h00;
    #3;
    chk("rst_data", DATA, 8'h00);
    chk("rst_done", {7'd0, DONE}, 8'h00);
    chk("rst_error", {7'd0, ERROR}, 8'h00);
    chk("rst_busy", {7'd0, BUSY}, 8'h00);
    chk("rst_stp", {7'd0, STP}, 8'h00);
    chk("rst_out", ULPI_DATA_OUT, 8'h00);
    chk("rst_oe", {7'd0, ULPI_DATA_OE}, 8'h00);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Basic read of 0x16 returning 0x5A, fastest PHY.
    READ_DATA = 1'b1; ADDR = 6'h16;
    step(0, 0, 8'h00);                       // E0
    chk("b_out", ULPI_DATA_OUT, 8'hD6);
    chk("b_oe", {7'd0, ULPI_DATA_OE}, 8'h01);
    chk("b_busy", {7'd0, BUSY}, 8'h01);
    step(0, 1, 8'h00);                       // E1, request still high but busy
    READ_DATA = 1'b0; ADDR = 6'h3F;
    chk("b_oe_drop", {7'd0, ULPI_DATA_OE}, 8'h00);
    chk("b_out_drop", ULPI_DATA_OUT, 8'h00);
    step(1, 0, 8'h00);                       // E2
    chk("b_done_early", {7'd0, DONE}, 8'h00);
    step(1, 0, 8'h5A);                       // E3
    chk("b_done", {7'd0, DONE}, 8'h01);
    chk("b_data", DATA, 8'h5A);
    chk("b_busy_e3", {7'd0, BUSY}, 8'h01);
    READ_DATA = 1'b1; ADDR = 6'h0A;          // back-to-back request
    step(0, 0, 8'h00);                       // E4
    chk("b_done_clr", {7'd0, DONE}, 8'h00);
    chk("b_busy_clr", {7'd0, BUSY}, 8'h00);
    chk("b_data_hold", DATA, 8'h5A);

    // NXT stalled three cycles, read of 0x0A returning 0x24.
    step(0, 0, 8'h00);                       // E0
    READ_DATA = 1'b0;
    chk("s_out0", ULPI_DATA_OUT, 8'hCA);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'h00);
      chk("s_out_hold", ULPI_DATA_OUT, 8'hCA);
      chk("s_oe_hold", {7'd0, ULPI_DATA_OE}, 8'h01);
    end
    step(0, 1, 8'h00);                       // E4
    chk("s_oe_drop", {7'd0, ULPI_DATA_OE}, 8'h00);
    step(1, 0, 8'h00);                       // E5
    chk("s_done_early", {7'd0, DONE}, 8'h00);
    step(1, 0, 8'h24);                       // E6
    chk("s_done", {7'd0, DONE}, 8'h01);
    chk("s_data", DATA, 8'h24);
    step(0, 0, 8'h00);                       // E7
    chk("s_busy_clr", {7'd0, BUSY}, 8'h00);

    // DIR rises in TXCMD before NXT; command is re-issued from the latched address.
    READ_DATA = 1'b1; ADDR = 6'h01;
    step(0, 0, 8'h00);
    READ_DATA = 1'b0; ADDR = 6'h3F;
    chk("a_out", ULPI_DATA_OUT, 8'hC1);
    step(1, 0, 8'h00);
    chk("a_oe_abort", {7'd0, ULPI_DATA_OE}, 8'h00);
    chk("a_busy", {7'd0, BUSY}, 8'h01);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 8'h00);
      chk("a_oe_wait", {7'd0, ULPI_DATA_OE}, 8'h00);
    end
    step(0, 0, 8'h00);
    chk("a_reissue", ULPI_DATA_OUT, 8'hC1);
    chk("a_reissue_oe", {7'd0, ULPI_DATA_OE}, 8'h01);
    step(0, 1, 8'h00);
    step(1, 0, 8'h00);
    step(1, 0, 8'h81);
    chk("a_done", {7'd0, DONE}, 8'h01);
    chk("a_err", {7'd0, ERROR}, 8'h00);
    chk("a_data", DATA, 8'h81);
    step(0, 0, 8'h00);
    chk("a_busy_clr", {7'd0, BUSY}, 8'h00);

    // RX preempts in TURN_IN four times: three retries then ERROR.
    READ_DATA = 1'b1; ADDR = 6'h02;
    step(0, 0, 8'h00);
    READ_DATA = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 8'h00);
      step(1, 1, 8'h00);
      chk("r_oe", {7'd0, ULPI_DATA_OE}, 8'h00);
      chk("r_done", {7'd0, DONE}, 8'h00);
      if (i < 3) begin
        chk("r_err_early", {7'd0, ERROR}, 8'h00);
        chk("r_busy", {7'd0, BUSY}, 8'h01);
        step(0, 0, 8'h00);
        chk("r_reissue", ULPI_DATA_OUT, 8'hC2);
      end else begin
        chk("r_err", {7'd0, ERROR}, 8'h01);
        chk("r_busy_clr", {7'd0, BUSY}, 8'h00);
      end
    end
    step(0, 0, 8'h00);
    chk("r_err_clr", {7'd0, ERROR}, 8'h00);

    // NXT accepted but DIR never rises: timeout after four TURN_IN cycles.
    READ_DATA = 1'b1; ADDR = 6'h03;
    step(0, 0, 8'h00);
    READ_DATA = 1'b0;
    step(0, 1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'h00);
      chk("t_err_early", {7'd0, ERROR}, 8'h00);
      chk("t_busy", {7'd0, BUSY}, 8'h01);
    end
    step(0, 0, 8'h00);
    chk("t_err", {7'd0, ERROR}, 8'h01);
    chk("t_busy_clr", {7'd0, BUSY}, 8'h00);
    chk("t_done", {7'd0, DONE}, 8'h00);
    step(0, 0, 8'h00);
    chk("t_err_clr", {7'd0, ERROR}, 8'h00);

    // Reset while in READ, then a clean read of 0x00 returning 0x24.
    READ_DATA = 1'b1; ADDR = 6'h04;
    step(0, 0, 8'h00);
    READ_DATA = 1'b0;
    step(0, 1, 8'h00);
    step(1, 0, 8'h00);
    chk("x_state_read", {5'd0, state_dbg}, 8'h04);
    rst = 1'b1;
    #2;
    chk("x_data", DATA, 8'h00);
    chk("x_busy", {7'd0, BUSY}, 8'h00);
    chk("x_done", {7'd0, DONE}, 8'h00);
    chk("x_err", {7'd0, ERROR}, 8'h00);
    chk("x_oe", {7'd0, ULPI_DATA_OE}, 8'h00);
    chk("x_state", {5'd0, state_dbg}, 8'h00);
    rst = 1'b0; DIR = 1'b0;
    @(posedge clk); #1;
    READ_DATA = 1'b1; ADDR = 6'h00;
    step(0, 0, 8'h00);
    READ_DATA = 1'b0;
    chk("x2_out", ULPI_DATA_OUT, 8'hC0);
    step(0, 1, 8'h00);
    step(1, 0, 8'h00);
    step(1, 0, 8'h24);
    chk("x2_done", {7'd0, DONE}, 8'h01);
    chk("x2_data", DATA, 8'h24);
    step(0, 0, 8'h00);
    chk("x2_busy_clr", {7'd0, BUSY}, 8'h00);
    chk("x2_stp", {7'd0, STP}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
